// File: rtl/p2s_multi.sv
`default_nettype none
// ============================================================================
//  Module   : p2s_multi
//  Purpose  : Multi-lane parallel-to-serial converter for chains of external
//             shift registers (74x164 / 74x595 style LED and 7-segment
//             drivers). All lanes share one serial clock. The block offers a
//             programmable divider, a selectable bit order, a storage-latch
//             strobe at end of frame and an idle/ready handshake.
//  Ports    : clk     - system clock, rising edge
//             rst     - synchronous reset, active low
//             start   - frame request; its rising edge loads a frame in idle
//             P_Data  - lane c = P_Data[c*DATA_BITS +: DATA_BITS]
//             s_clk   - registered serial shift clock
//             s_clrn  - active-low clear to the external registers
//             sout    - serial data, one bit per lane
//             s_latch - storage-latch strobe issued after the last bit
//             ready   - high while idle and able to accept a frame
//  Macro    : P2S_CLRN_PULSE_EN - when defined, a CLEAR state drives s_clrn
//             low for CLK_DIV cycles between the load and the first bit.
//             When undefined, s_clrn is tied high.
//  Revision : 1.0 - initial multi-lane release
// ============================================================================
module p2s_multi #(
  parameter int DATA_BITS = 64,
  parameter int NUM_CH    = 1,
  parameter int CNT_BITS  = 7,
  parameter int CLK_DIV   = 1,
  parameter int DIV_BITS  = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CH*DATA_BITS-1:0] P_Data,
  output logic                        s_clk,
  output logic                        s_clrn,
  output logic [NUM_CH-1:0]           sout,
  output logic                        s_latch,
  output logic                        ready
);

  localparam logic [DIV_BITS-1:0] c_div_last = DIV_BITS'(CLK_DIV - 1);
  localparam logic [CNT_BITS-1:0] c_cnt_last = CNT_BITS'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  s_clk_q, s_clk_d;
  logic                  s_latch_q, s_latch_d;
  logic                  ready_q, ready_d;
  logic                  start_q;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [DIV_BITS-1:0]   div_q, div_d;
  logic [DATA_BITS-1:0]  buf_q [NUM_CH];
  logic [DATA_BITS-1:0]  buf_d [NUM_CH];
  logic                  div_last;
  logic                  load_evt;
`ifdef P2S_CLRN_PULSE_EN
  logic                  s_clrn_q, s_clrn_d;
`endif

  assign div_last = (div_q == c_div_last);
  assign load_evt = start && !start_q;

  always_comb begin
    state_d   = state_q;
    s_clk_d   = s_clk_q;
    s_latch_d = s_latch_q;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    buf_d     = buf_q;
`ifdef P2S_CLRN_PULSE_EN
    s_clrn_d  = s_clrn_q;
`endif

    case (state_q)
      ST_IDLE: begin
        s_clk_d   = 1'b0;
        s_latch_d = 1'b0;
        ready_d   = 1'b1;
        if (load_evt) begin
          for (int c = 0; c < NUM_CH; c++) begin
            buf_d[c] = P_Data[c*DATA_BITS +: DATA_BITS];
          end
          cnt_d   = '0;
          div_d   = '0;
          ready_d = 1'b0;
`ifdef P2S_CLRN_PULSE_EN
          s_clrn_d = 1'b0;
          state_d  = ST_CLEAR;
`else
          state_d  = ST_SHIFT;
`endif
        end
      end

`ifdef P2S_CLRN_PULSE_EN
      ST_CLEAR: begin
        s_clk_d = 1'b0;
        if (div_last) begin
          div_d    = '0;
          s_clrn_d = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          div_d = div_q + DIV_BITS'(1);
        end
      end
`endif

      ST_SHIFT: begin
        if (!div_last) begin
          div_d = div_q + DIV_BITS'(1);
        end else begin
          div_d = '0;
          if (!s_clk_q) begin
            s_clk_d = 1'b1;
          end else begin
            // End of the high phase: advance every lane by one bit so the
            // next bit is already settled for the whole following low phase.
            s_clk_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
              if (MSB_FIRST != 0) begin
                buf_d[c] = {buf_q[c][DATA_BITS-2:0], 1'b0};
              end else begin
                buf_d[c] = {1'b0, buf_q[c][DATA_BITS-1:1]};
              end
            end
            cnt_d = cnt_q + CNT_BITS'(1);
            if (cnt_q == c_cnt_last) begin
              s_latch_d = 1'b1;
              state_d   = ST_LATCH;
            end
          end
        end
      end

      ST_LATCH: begin
        s_clk_d = 1'b0;
        if (div_last) begin
          div_d     = '0;
          s_latch_d = 1'b0;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          div_d = div_q + DIV_BITS'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      s_clk_q   <= 1'b0;
      s_latch_q <= 1'b0;
      ready_q   <= 1'b0;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        buf_q[c] <= '0;
      end
`ifdef P2S_CLRN_PULSE_EN
      s_clrn_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      s_clk_q   <= s_clk_d;
      s_latch_q <= s_latch_d;
      ready_q   <= ready_d;
      start_q   <= start;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      buf_q     <= buf_d;
`ifdef P2S_CLRN_PULSE_EN
      s_clrn_q  <= s_clrn_d;
`endif
    end
  end

  // Each lane presents the bit at its output end of the buffer.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    if (MSB_FIRST != 0) begin : g_msb
      assign sout[c] = buf_q[c][DATA_BITS-1];
    end else begin : g_lsb
      assign sout[c] = buf_q[c][0];
    end
  end

  assign s_clk   = s_clk_q;
  assign s_latch = s_latch_q;
  assign ready   = ready_q;
`ifdef P2S_CLRN_PULSE_EN
  assign s_clrn  = s_clrn_q;
`else
  assign s_clrn  = 1'b1;
`endif

endmodule
`default_nettype wire
